// File: rtl/neuron_learn_layer_seq.sv
// Time-multiplexed fully-connected learning layer: M neurons x N inputs sharing one MAC.
// Weights are held internally. An FSM sequences the forward pass, the optional
// weight-update pass and the back-propagated target averaging.
// Ports:
//   clock, reset_n             rising-edge clock, synchronous active-low reset
//   in_valid/in_ready          input handshake; in, expected_out and learn are captured on accept
//   out_valid/out_ready        result handshake; out and expected_in are held until accepted
//   out                        neuron outputs, unsigned Q0.DW, neuron j at [j*DW +: DW]
//   expected_in                target for the previous layer, input i at [i*DW +: DW]
//   w_rd_addr/w_rd_data        combinational read port for weight[j][i] at index j*N+i
//   act_max/act_min            per-neuron running max/min of out since reset
module neuron_learn_layer_seq #(
    parameter int unsigned N        = 16,
    parameter int unsigned M        = 47,
    parameter int unsigned DW       = 16,
    parameter int unsigned LR_SHIFT = 4,
    parameter int unsigned INIT_W   = 2**(DW-2)
) (
    input  logic                                      clock,
    input  logic                                      reset_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic                                      learn,
    input  logic [N*DW-1:0]                           in,
    input  logic [M*DW-1:0]                           expected_out,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [M*DW-1:0]                           out,
    output logic [N*DW-1:0]                           expected_in,
    input  logic [((M*N > 1) ? $clog2(M*N) : 1)-1:0]  w_rd_addr,
    output logic [DW-1:0]                             w_rd_data,
    output logic [M*DW-1:0]                           act_max,
    output logic [M*DW-1:0]                           act_min
);

    localparam int unsigned AD_W = (M*N > 1) ? $clog2(M*N) : 1;
    localparam int unsigned NI_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned MJ_W = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned PW   = 2*DW + 1;          // w*x and err*w products
    localparam int unsigned AW   = 2*DW + NI_W + 2;   // forward accumulator
    localparam int unsigned DPW  = 2*DW + 2;          // err*x product
    localparam int unsigned BW   = 2*DW + MJ_W + 2;   // back-propagation accumulator

    localparam logic signed [AW-1:0]  A_MAX = AW'((1 << DW) - 1);
    localparam logic signed [BW-1:0]  B_MAX = BW'((1 << DW) - 1);
    localparam logic signed [BW-1:0]  M_DIV = BW'(M);
    localparam logic signed [DPW-1:0] W_MAX = DPW'((1 << (DW-1)) - 1);
    localparam logic signed [DPW-1:0] W_MIN = -(DPW'(1 << (DW-1)));

    typedef enum logic [2:0] {S_IDLE, S_FWD, S_BWD, S_AVG, S_DONE} state_t;

    state_t                 state;
    logic [NI_W-1:0]        i_cnt;
    logic [MJ_W-1:0]        j_cnt;
    logic signed [AW-1:0]   acc;
    logic signed [BW-1:0]   bacc [N];
    logic signed [DW-1:0]   w    [M*N];
    logic [N*DW-1:0]        in_q;
    logic [M*DW-1:0]        exp_q;
    logic                   learn_q;

    logic [AD_W-1:0]        widx;
    logic [DW-1:0]          x_u;
    logic [DW-1:0]          out_j;
    logic [DW-1:0]          exp_j;
    logic signed [DW:0]     x_s;
    logic signed [DW:0]     err;
    logic signed [DW-1:0]   w_cur;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   bprod;
    logic signed [AW-1:0]   acc_sum;
    logic signed [AW-1:0]   acc_shr;
    logic [DW-1:0]          out_new;
    logic signed [DPW-1:0]  dprod;
    logic signed [DPW-1:0]  wsum;
    logic [DW-1:0]          w_new;
    logic signed [BW-1:0]   bacc_sum;
    logic signed [BW-1:0]   bq;
    logic signed [BW-1:0]   avg_sum;
    logic [DW-1:0]          avg_new;

    // Shared datapath for the current (j, i) step of every pass
    always_comb begin
        widx    = AD_W'(j_cnt) * AD_W'(N) + AD_W'(i_cnt);
        x_u     = in_q[int'(i_cnt)*DW +: DW];
        x_s     = signed'({1'b0, x_u});
        w_cur   = w[widx];
        out_j   = out[int'(j_cnt)*DW +: DW];
        exp_j   = exp_q[int'(j_cnt)*DW +: DW];

        // Forward MAC and output clamp to [0, 2**DW-1]
        prod    = PW'(w_cur) * PW'(x_s);
        acc_sum = acc + AW'(prod);
        acc_shr = acc_sum >>> (DW-1);
        out_new = DW'(acc_shr);
        if (acc_sum < 0) begin
            out_new = '0;
        end else if (acc_shr > A_MAX) begin
            out_new = '1;
        end

        // Weight update, saturated to the signed weight range
        err     = signed'({1'b0, exp_j}) - signed'({1'b0, out_j});
        dprod   = DPW'(err) * DPW'(x_s);
        wsum    = DPW'(w_cur) + (dprod >>> (DW + LR_SHIFT));
        w_new   = DW'(wsum);
        if (wsum > W_MAX) begin
            w_new = DW'(W_MAX);
        end else if (wsum < W_MIN) begin
            w_new = DW'(W_MIN);
        end

        // Error back-propagation through the pre-update weight
        bprod    = PW'(err) * PW'(w_cur);
        bacc_sum = bacc[i_cnt] + BW'(bprod);

        // Averaging: signed division truncates toward zero
        bq      = (bacc[i_cnt] >>> (DW-1)) / M_DIV;
        avg_sum = bq + signed'(BW'(x_u));
        avg_new = DW'(avg_sum);
        if (avg_sum < 0) begin
            avg_new = '0;
        end else if (avg_sum > B_MAX) begin
            avg_new = '1;
        end
    end

    // Committed weight read port
    assign w_rd_data = (int'(w_rd_addr) < int'(M*N)) ? w[w_rd_addr] : '0;

    // Sequencer and all registered state
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out         <= '0;
            expected_in <= '0;
            act_max     <= '0;
            act_min     <= '1;
            i_cnt       <= '0;
            j_cnt       <= '0;
            acc         <= '0;
            in_q        <= '0;
            exp_q       <= '0;
            learn_q     <= 1'b0;
            for (int k = 0; k < int'(M*N); k++) begin
                w[k] <= DW'(INIT_W);
            end
            for (int k = 0; k < int'(N); k++) begin
                bacc[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_q     <= in;
                        exp_q    <= expected_out;
                        learn_q  <= learn;
                        in_ready <= 1'b0;
                        i_cnt    <= '0;
                        j_cnt    <= '0;
                        acc      <= '0;
                        for (int k = 0; k < int'(N); k++) begin
                            bacc[k] <= '0;
                        end
                        state    <= S_FWD;
                    end
                end
                S_FWD: begin
                    if (i_cnt == NI_W'(N-1)) begin
                        out[int'(j_cnt)*DW +: DW] <= out_new;
                        if (out_new > act_max[int'(j_cnt)*DW +: DW]) begin
                            act_max[int'(j_cnt)*DW +: DW] <= out_new;
                        end
                        if (out_new < act_min[int'(j_cnt)*DW +: DW]) begin
                            act_min[int'(j_cnt)*DW +: DW] <= out_new;
                        end
                        acc   <= '0;
                        i_cnt <= '0;
                        if (j_cnt == MJ_W'(M-1)) begin
                            j_cnt <= '0;
                            state <= learn_q ? S_BWD : S_DONE;
                        end else begin
                            j_cnt <= j_cnt + MJ_W'(1);
                        end
                    end else begin
                        acc   <= acc_sum;
                        i_cnt <= i_cnt + NI_W'(1);
                    end
                end
                S_BWD: begin
                    w[widx]     <= w_new;
                    bacc[i_cnt] <= bacc_sum;
                    if (i_cnt == NI_W'(N-1)) begin
                        i_cnt <= '0;
                        if (j_cnt == MJ_W'(M-1)) begin
                            j_cnt <= '0;
                            state <= S_AVG;
                        end else begin
                            j_cnt <= j_cnt + MJ_W'(1);
                        end
                    end else begin
                        i_cnt <= i_cnt + NI_W'(1);
                    end
                end
                S_AVG: begin
                    expected_in[int'(i_cnt)*DW +: DW] <= avg_new;
                    if (i_cnt == NI_W'(N-1)) begin
                        i_cnt <= '0;
                        state <= S_DONE;
                    end else begin
                        i_cnt <= i_cnt + NI_W'(1);
                    end
                end
                S_DONE: begin
                    // First DONE cycle raises out_valid; results then hold until accepted
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_learn_layer_seq.sv
// Directed bench for neuron_learn_layer_seq with N=2, M=3, DW=8, LR_SHIFT=2.
// Instance dut uses INIT_W=64; instance dut5 uses INIT_W=127 for the clamp case.
// Input buses and out_ready are shared; each instance has its own in_valid.
module tb_neuron_learn_layer_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_valid5;
    logic        in_ready, in_ready5;
    logic        learn;
    logic [15:0] in_vec;
    logic [23:0] exp_vec;
    logic        out_valid, out_valid5;
    logic        out_ready;
    logic [23:0] out_vec, out_vec5;
    logic [15:0] exp_in, exp_in5;
    logic [2:0]  w_rd_addr;
    logic [7:0]  w_rd_data, w_rd_data5;
    logic [23:0] act_max, act_max5;
    logic [23:0] act_min, act_min5;

    int errors = 0;
    int checks = 0;
    int lat;

    always #5 clock = ~clock;

    neuron_learn_layer_seq #(.N(2), .M(3), .DW(8), .LR_SHIFT(2), .INIT_W(64)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .learn(learn), .in(in_vec), .expected_out(exp_vec), .out_valid(out_valid),
        .out_ready(out_ready), .out(out_vec), .expected_in(exp_in), .w_rd_addr(w_rd_addr),
        .w_rd_data(w_rd_data), .act_max(act_max), .act_min(act_min)
    );

    neuron_learn_layer_seq #(.N(2), .M(3), .DW(8), .LR_SHIFT(2), .INIT_W(127)) dut5 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .learn(learn), .in(in_vec), .expected_out(exp_vec), .out_valid(out_valid5),
        .out_ready(out_ready), .out(out_vec5), .expected_in(exp_in5), .w_rd_addr(w_rd_addr),
        .w_rd_data(w_rd_data5), .act_max(act_max5), .act_min(act_min5)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Read all six weights of one instance; returns aligned to posedge+1
    task automatic check_w(input logic sel, input int val, input string tag);
        for (int a = 0; a < 6; a++) begin
            w_rd_addr = 3'(a);
            @(negedge clock);
            check($sformatf("%s[%0d]", tag, a), sel ? 64'(w_rd_data5) : 64'(w_rd_data), 64'(val));
        end
        @(posedge clock);
        #1;
    endtask

    // Present one vector, wait for out_valid (bounded), return accept-to-valid latency
    task automatic start(input logic sel, input logic [15:0] x, input logic [23:0] e,
                         input logic l, output int latency);
        in_vec  = x;
        exp_vec = e;
        learn   = l;
        if (sel) in_valid5 = 1'b1; else in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        in_valid5 = 1'b0;
        latency   = 0;
        while (!(sel ? out_valid5 : out_valid) && latency < 100) begin
            @(posedge clock);
            #1;
            latency++;
        end
    endtask

    task automatic handshake(input logic sel, input string tag);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check({tag, "_ov_low"}, sel ? 64'(out_valid5) : 64'(out_valid), 64'd0);
        check({tag, "_rdy_high"}, sel ? 64'(in_ready5) : 64'(in_ready), 64'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_valid5 = 1'b0;
        out_ready = 1'b0;
        learn     = 1'b0;
        in_vec    = '0;
        exp_vec   = '0;
        w_rd_addr = '0;

        // 1: reset state
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_act_min", 64'(act_min), 64'hFFFFFF);
        check("rst_act_max", 64'(act_max), 64'd0);
        check("rst_out", 64'(out_vec), 64'd0);
        check("rst_exp_in", 64'(exp_in), 64'd0);
        check_w(1'b0, 64, "rst_w");

        // 2: forward only, 0.5*0.5*2 = 0.5 -> 128 per neuron
        start(1'b0, {8'd128, 8'd128}, 24'd0, 1'b0, lat);
        check("t2_latency", 64'(lat), 64'd7);
        check("t2_out", 64'(out_vec), 64'h808080);
        check("t2_exp_in", 64'(exp_in), 64'd0);
        handshake(1'b0, "t2");
        check_w(1'b0, 64, "t2_w");
        check("t2_act_max", 64'(act_max), 64'h808080);
        check("t2_act_min", 64'(act_min), 64'h808080);

        // 3: learn, err=127: w=64+15=79, bacc=3*8128 -> 190/3=63 -> 128+63=191
        start(1'b0, {8'd128, 8'd128}, 24'hFFFFFF, 1'b1, lat);
        check("t3_latency", 64'(lat), 64'd15);
        check("t3_out", 64'(out_vec), 64'h808080);
        check("t3_exp_in", 64'(exp_in), 64'hBFBF);
        check_w(1'b0, 79, "t3_w");

        // 4: consumer stall in DONE
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            check("t4_ov_hold", 64'(out_valid), 64'd1);
            check("t4_rdy_low", 64'(in_ready), 64'd0);
            check("t4_out_hold", 64'(out_vec), 64'h808080);
        end
        check("t4_exp_in_hold", 64'(exp_in), 64'hBFBF);
        handshake(1'b0, "t4");

        // Forward with learned weights: 79*128*2>>7 = 158; expected_in untouched
        start(1'b0, {8'd128, 8'd128}, 24'd0, 1'b0, lat);
        check("t4b_latency", 64'(lat), 64'd7);
        check("t4b_out", 64'(out_vec), 64'h9E9E9E);
        check("t4b_exp_in", 64'(exp_in), 64'hBFBF);
        check("t4b_act_max", 64'(act_max), 64'h9E9E9E);
        check("t4b_act_min", 64'(act_min), 64'h808080);
        handshake(1'b0, "t4b");
        check_w(1'b0, 79, "t4b_w");

        // 5: INIT_W=127, in=255: out clamps to 255; err=-255 -> w=127-64=63, exp_in=255-253=2
        start(1'b1, {8'd255, 8'd255}, 24'd0, 1'b1, lat);
        check("t5_latency", 64'(lat), 64'd15);
        check("t5_out", 64'(out_vec5), 64'hFFFFFF);
        check("t5_exp_in", 64'(exp_in5), 64'h0202);
        check("t5_act_max", 64'(act_max5), 64'hFFFFFF);
        check_w(1'b1, 63, "t5_w");
        handshake(1'b1, "t5");
        // Second pass: out=251, err=-251 -> w=63-63=0, exp_in=255-123=132
        start(1'b1, {8'd255, 8'd255}, 24'd0, 1'b1, lat);
        check("t5b_out", 64'(out_vec5), 64'hFBFBFB);
        check("t5b_exp_in", 64'(exp_in5), 64'h8484);
        check_w(1'b1, 0, "t5b_w");
        handshake(1'b1, "t5b");

        // 6: reset in the middle of the forward pass
        in_vec   = {8'd128, 8'd128};
        exp_vec  = 24'd0;
        learn    = 1'b0;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("t6_in_ready", 64'(in_ready), 64'd1);
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_out", 64'(out_vec), 64'd0);
        check_w(1'b0, 64, "t6_w");
        repeat (8) @(posedge clock);
        #1;
        check("t6_no_partial", 64'(out_valid), 64'd0);
        start(1'b0, {8'd128, 8'd128}, 24'd0, 1'b0, lat);
        check("t6_latency", 64'(lat), 64'd7);
        check("t6_out_new", 64'(out_vec), 64'h808080);
        handshake(1'b0, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
